pixel_frame_sequencer: RTL and testbench
========================================

# pixel_frame_sequencer

- Scans one IMG_W×IMG_H binary-image frame out of pixel memory in row-major order.
- Feeds each byte into the BinaryToPNG converter and collects the converter's R/G/B result.
- Delivers the results to the PNG writer over a valid/ready stream with frame and line markers.
- Turns the free-running converter into a flow-controlled stage: credit-based read issue plus a small output FIFO, so downstream backpressure never loses a pixel.

## Interface
- IMG_W, 256, pixels per line
- IMG_H, 256, lines per frame
- CONV_LAT, 1, converter latency in cycles (binary_image_pixel to png_pixel_*)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥ 2+CONV_LAT for full throughput)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last pixel handshake
- mem_rd_en  out  1  pixel memory read strobe
- mem_addr  out  $clog2(IMG_W*IMG_H)  read address, y*IMG_W+x
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd_en
- conv_pixel  out  8  to converter binary_image_pixel
- conv_valid  out  1  conv_pixel carries a real pixel
- conv_r, conv_g, conv_b  in  8 each  from converter png_pixel_r/g/b
- out_valid  out  1  output pixel available
- out_ready  in  1  downstream accepts
- out_r, out_g, out_b  out  8 each  pixel data
- out_sof, out_eol, out_eof  out  1 each  first pixel of frame / last of line / last of frame

## Operation
- FSM states:
  - IDLE: start → RUN; clear x, y, credits.
  - RUN: issue reads; after the read of the last pixel (x=IMG_W-1, y=IMG_H-1) → DRAIN.
  - DRAIN: wait until in-flight = 0 and FIFO empty → DONE.
  - DONE: assert done for one cycle → IDLE.
- Read issue: mem_rd_en=1 when in RUN and in_flight + fifo_count < FIFO_DEPTH.
  - x increments on every issued read; at x=IMG_W-1, x wraps to 0 and y increments.
- Data path:
  - conv_pixel = mem_rdata, conv_valid = registered mem_rd_en.
  - Side-band tags (sof, eol, eof) travel in a shift register of length 1+CONV_LAT alongside the data.
  - When the delayed valid emerges, conv_r/g/b plus the tags are pushed into the FIFO.
- in_flight counter:
  - +1 on each issued read, −1 on each FIFO push.
  - Never exceeds 1+CONV_LAT.
  - FIFO can never overflow; a push to a full FIFO is a design error (assertion).
- Pop occurs on out_valid && out_ready. The FIFO head drives out_* (first-word-fall-through).
- busy is high in RUN, DRAIN; low in IDLE and DONE.
- start is ignored unless the FSM is in IDLE.
- conv_pixel holds 0 when conv_valid=0.
- rst at any time returns the block to IDLE and discards the FIFO, in_flight, tags and counters. The same-cycle start is ignored.
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, conv_pixel=0, conv_valid=0, out_valid=0, out_r/g/b=0, out_sof/eol/eof=0.

## Timing
- start sampled high at edge of cycle 0 → cycle 1: mem_rd_en=1, mem_addr=0.
- Cycle 2: conv_valid=1, conv_pixel=mem[0].
- Cycle 2+CONV_LAT: push into FIFO.
- Cycle 3+CONV_LAT: first out_valid with out_sof=1 (cycle 4 at defaults).
- With out_ready held high: one pixel per cycle, no bubbles.
  - Last handshake at cycle 3+CONV_LAT+IMG_W*IMG_H−1.
  - done pulses the following cycle.
- out_ready low: reads stall within FIFO_DEPTH−fifo_count−in_flight cycles.
  - Output data and markers stay stable while out_valid && !out_ready.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.

## Configuration
- PFS_CHECKSUM_EN defined:
  - Adds output checksum[15:0], a running modulo-2^16 sum of out_r+out_g+out_b over handshaken pixels.
  - Cleared on start acceptance and on rst.
  - Stable from done until the next start.
- PFS_CHECKSUM_EN undefined: no checksum port, no related logic.

## Structure
- Shared package pfs_pkg:
  - State enum (IDLE, RUN, DRAIN, DONE).
  - Tag struct {sof, eol, eof}.
  - Pixel struct {r, g, b, tag}.
- One sub-module: pfs_out_fifo, a parameterized synchronous FWFT FIFO of the pixel struct with push/pop/count.
- Address, credit and tag pipeline stay in the top.

## Test plan
- IMG_W=4, IMG_H=2, memory = 0x00..0x07, converter model R=G=B=pixel, out_ready=1.
  - Expect 8 outputs in order, first at cycle 4.
  - Markers: sof on pixel 0, eol on pixels 3 and 7, eof on pixel 7.
  - done at cycle 12.
- Same frame, out_ready toggling 1,0,0,1,… → order and markers unchanged, no drop or duplicate, and fifo_count ≤ 4 throughout.
- out_ready=0 from cycle 0 → exactly FIFO_DEPTH (4) reads issued, then mem_rd_en stays 0 until ready rises.
- start pulsed again while busy → ignored; a single frame of 8 pixels with one done.
- rst asserted at cycle 6 mid-frame → next cycle all outputs at reset values; a new start gives a clean frame from address 0.
- PFS_CHECKSUM_EN with the first frame → checksum = 3×(0+1+…+7) = 0x0054 at done.

Source files
------------

// File: rtl/pfs_pkg.sv
// Shared types for the pixel frame sequencer: FSM states, side-band tags and the FIFO pixel payload.
package pfs_pkg;

    localparam int unsigned PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } tag_t;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
        tag_t             tag;
    } pixel_t;

    // Counter/pointer width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/pfs_out_fifo.sv
// Synchronous first-word-fall-through FIFO of pixel_t; DEPTH must be a power of two >= 2.
module pfs_out_fifo
    import pfs_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = clog2_min1(DEPTH),
    localparam int unsigned CNTW  = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  pixel_t          din,
    input  logic            pop,
    output pixel_t          head_c,
    output logic            empty_c,
    output logic [CNTW-1:0] count
);

    pixel_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            full_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CNTW'(push) - CNTW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the head is qualified by empty_c.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNTW'(DEPTH));
    assign count   = count_q;

    // Credit logic upstream must make these unreachable.
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full_c && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty_c));

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Scans one IMG_W x IMG_H frame from pixel memory through the converter into a valid/ready stream.
// Optional running output checksum when PFS_CHECKSUM_EN is defined.
module pixel_frame_sequencer
    import pfs_pkg::*;
#(
    parameter  int unsigned IMG_W      = 256,
    parameter  int unsigned IMG_H      = 256,
    parameter  int unsigned CONV_LAT   = 1,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned AW         = clog2_min1(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    conv_pixel,
    output logic          conv_valid,
    input  logic [7:0]    conv_r,
    input  logic [7:0]    conv_g,
    input  logic [7:0]    conv_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_r,
    output logic [7:0]    out_g,
    output logic [7:0]    out_b,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof
`ifdef PFS_CHECKSUM_EN
    ,
    output logic [15:0]   checksum
`endif
);

    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned XW   = clog2_min1(IMG_W);
    localparam int unsigned PL   = CONV_LAT + 1;
    localparam int unsigned TW   = $bits(tag_t);
    localparam int unsigned FCW  = clog2_min1(FIFO_DEPTH) + 1;
    localparam int unsigned CW   = clog2_min1(FIFO_DEPTH + PL + 1) + 1;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XW-1:0]   x_q, x_d;
    logic            rd_en_q, rd_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PL-1:0]   vld_q, vld_d;
    tag_t [PL-1:0]   tag_q, tag_d;
    logic [CW-1:0]   in_flight_q, in_flight_d;
    logic [CW-1:0]   fifo_count_nx;

    tag_t            issue_tag;
    pixel_t          push_pix, head_pix, out_pix;
    logic            push, pop, fifo_empty;
    logic [FCW-1:0]  fifo_count;

    // Tags for the pixel addressed this cycle; only meaningful when a read issues.
    always_comb begin
        issue_tag.sof = (addr_q == '0);
        issue_tag.eol = (x_q == XW'(IMG_W - 1));
        issue_tag.eof = (addr_q == AW'(NPIX - 1));
    end

    always_comb begin
        push_pix.r   = conv_r;
        push_pix.g   = conv_g;
        push_pix.b   = conv_b;
        push_pix.tag = tag_q[PL-1];
    end

    assign push          = vld_q[PL-1];
    assign pop           = !fifo_empty && out_ready;
    assign fifo_count_nx = CW'(fifo_count) + CW'(push) - CW'(pop);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        x_d         = x_q;
        vld_d       = PL'({vld_q, rd_en_q});
        tag_d       = (PL * TW)'({tag_q, issue_tag});
        in_flight_d = in_flight_q + CW'(rd_en_q) - CW'(push);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    addr_d      = '0;
                    x_d         = '0;
                    in_flight_d = '0;
                end
            end
            RUN: begin
                if (rd_en_q) begin
                    addr_d = addr_q + AW'(1);
                    x_d    = (x_q == XW'(IMG_W - 1)) ? '0 : x_q + XW'(1);
                    if (issue_tag.eof) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Look at next-cycle occupancy so done follows the last handshake directly.
                if (in_flight_d == '0 && fifo_count_nx == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A read may issue only if the FIFO can hold it plus everything already in flight.
        rd_en_d = (state_d == RUN) && ((in_flight_d + fifo_count_nx) < CW'(FIFO_DEPTH));
        busy_d  = (state_d == RUN) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            x_q         <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_q       <= '0;
            tag_q       <= '0;
            in_flight_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            x_q         <= x_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vld_q       <= vld_d;
            tag_q       <= tag_d;
            in_flight_q <= in_flight_d;
        end
    end

    pfs_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .din     (push_pix),
        .pop     (pop),
        .head_c  (head_pix),
        .empty_c (fifo_empty),
        .count   (fifo_count)
    );

    a_in_flight_bound: assert property (@(posedge clk) disable iff (rst) in_flight_q <= CW'(PL));

    assign out_pix    = fifo_empty ? '0 : head_pix;
    assign out_valid  = !fifo_empty;
    assign out_r      = out_pix.r;
    assign out_g      = out_pix.g;
    assign out_b      = out_pix.b;
    assign out_sof    = out_pix.tag.sof;
    assign out_eol    = out_pix.tag.eol;
    assign out_eof    = out_pix.tag.eof;

    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_rd_en  = rd_en_q;
    assign mem_addr   = addr_q;
    assign conv_valid = vld_q[0];
    assign conv_pixel = vld_q[0] ? mem_rdata : 8'h00;

`ifdef PFS_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start) begin
            csum_d = '0;
        end else if (pop) begin
            csum_d = csum_q + 16'(out_r) + 16'(out_g) + 16'(out_b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Scoreboard bench for pixel_frame_sequencer on a 4x2 frame; covers PFS_CHECKSUM_EN when defined.
module tb_pixel_frame_sequencer;
    import pfs_pkg::*;

    localparam int unsigned W     = 4;
    localparam int unsigned H     = 2;
    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned N     = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, mem_rd_en, conv_valid, out_valid;
    logic       out_ready = 1'b1;
    logic       out_sof, out_eol, out_eof;
    logic [2:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] conv_r = 8'h00, conv_g = 8'h00, conv_b = 8'h00;
    logic [7:0] conv_pixel, out_r, out_g, out_b;
`ifdef PFS_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [7:0]  mem_arr [N];
    logic [26:0] sb [$];
    int conv_mode = 0, ready_mode = 0, pat_i = 0, cyc = 0, t0 = 0;
    int n_checks = 0, n_errors = 0;
    int rd_cnt = 0, exp_addr = 0, frame_pix = 0, first_rel = 0;
    int done_cnt = 0, done_rel = 0, max_cnt = 0;

    always #5 clk = ~clk;

    pixel_frame_sequencer #(
        .IMG_W      (W),
        .IMG_H      (H),
        .CONV_LAT   (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .conv_pixel (conv_pixel),
        .conv_valid (conv_valid),
        .conv_r     (conv_r),
        .conv_g     (conv_g),
        .conv_b     (conv_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof)
`ifdef PFS_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    function automatic logic [23:0] conv_fn(input logic [7:0] p);
        if (conv_mode == 0) return {p, p, p};
        return {p, p + 8'h40, p ^ 8'hA5};
    endfunction

    // Memory with one-cycle read latency and a free-running one-cycle converter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rdata <= mem_arr[mem_addr];
        {conv_r, conv_g, conv_b} <= conv_fn(conv_pixel);
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
                pat_i++;
            end
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                check_eq("rd_addr", 32'(mem_addr), 32'(exp_addr));
                exp_addr++;
                rd_cnt++;
            end
            if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
            if (out_valid && out_ready) begin
                if (frame_pix == 0) first_rel = cyc - t0 + 1;
                frame_pix++;
                if (sb.size() == 0) begin
                    check_eq("extra_pixel", 32'(sb.size()), 32'd1);
                end else begin
                    logic [26:0] want;
                    want = sb.pop_front();
                    check_eq("pixel", 32'({out_r, out_g, out_b, out_sof, out_eol, out_eof}), 32'(want));
                end
            end
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0 + 1;
            end
        end
    end

    task automatic load_frame(input int mode);
        conv_mode = mode;
        for (int i = 0; i < N; i++) begin
            mem_arr[i] = (mode == 0) ? 8'(i) : 8'(16 * i + 3);
        end
        for (int i = 0; i < N; i++) begin
            sb.push_back({conv_fn(mem_arr[i]), i == 0, (i % W) == (W - 1), i == (N - 1)});
        end
    endtask

    task automatic start_frame();
        rd_cnt = 0; exp_addr = 0; frame_pix = 0; done_cnt = 0; max_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) @(posedge clk);
        check_eq({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic check_frame_end(input string tag);
        check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check_eq({tag, "_reads"}, 32'(rd_cnt), 32'(N));
        check_eq({tag, "_pixels"}, 32'(frame_pix), 32'(N));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ctl"}, 32'({busy, done, mem_rd_en, conv_valid, out_valid, out_sof, out_eol, out_eof}), 32'd0);
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_conv_pixel"}, 32'(conv_pixel), 32'd0);
        check_eq({tag, "_out_rgb"}, 32'({out_r, out_g, out_b}), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Full-rate frame.
        load_frame(0);
        start_frame();
        wait_done("t1", 100);
        check_eq("t1_first_cycle", 32'(first_rel), 32'd4);
        check_eq("t1_done_cycle", 32'(done_rel), 32'd12);
        check_frame_end("t1");
`ifdef PFS_CHECKSUM_EN
        check_eq("t1_checksum", 32'(checksum), 32'h54);
`endif
        repeat (5) @(posedge clk);
        check_eq("t1_single_done", 32'(done_cnt), 32'd1);
`ifdef PFS_CHECKSUM_EN
        check_eq("t1_checksum_hold", 32'(checksum), 32'h54);
`endif

        // Toggling backpressure 1,0,0,1,...
        ready_mode = 1; pat_i = 0;
        load_frame(0);
        start_frame();
        wait_done("t2", 300);
        ready_mode = 0;
        check_frame_end("t2");
        check_eq("t2_fifo_bound", 32'(max_cnt <= int'(DEPTH)), 32'd1);

        // Held backpressure: reads stop after FIFO_DEPTH.
        ready_mode = 2;
        load_frame(0);
        start_frame();
        repeat (20) @(posedge clk);
        check_eq("t3_stalled_reads", 32'(rd_cnt), 32'(DEPTH));
        check_eq("t3_head_valid", 32'(out_valid), 32'd1);
        check_eq("t3_head_pixel", 32'({out_r, out_g, out_b, out_sof, out_eol, out_eof}), 32'(sb[0]));
        ready_mode = 0;
        wait_done("t3", 200);
        check_frame_end("t3");

        // Second start while busy is ignored.
        load_frame(0);
        start_frame();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("t4", 200);
        repeat (20) @(posedge clk);
        check_eq("t4_single_done", 32'(done_cnt), 32'd1);
        check_eq("t4_idle", 32'(busy), 32'd0);
        check_frame_end("t4");

        // Reset during cycle 6, then a clean frame with distinct R/G/B.
        load_frame(0);
        start_frame();
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_vals("abort");
        load_frame(1);
        start_frame();
        wait_done("t5", 100);
        check_eq("t5_first_cycle", 32'(first_rel), 32'd4);
        check_eq("t5_done_cycle", 32'(done_rel), 32'd12);
        check_frame_end("t5");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
